// File: rtl/nmea_pkg.sv
// Shared types and helpers for the NMEA position front end: parser states,
// ASCII constants, accumulator width and small character helpers.
package nmea_pkg;

  localparam int ACC_W = 28;

  typedef enum logic [3:0] {
    S_IDLE, S_TALKER, S_TIME, S_STATUS, S_LAT, S_LAT_HEM,
    S_LON, S_LON_HEM, S_TAIL, S_CK_HI, S_CK_LO, S_MAP
  } state_e;

  localparam logic [7:0] ASC_DOLLAR = 8'h24;
  localparam logic [7:0] ASC_COMMA  = 8'h2C;
  localparam logic [7:0] ASC_STAR   = 8'h2A;
  localparam logic [7:0] ASC_DOT    = 8'h2E;
  localparam logic [7:0] ASC_CR     = 8'h0D;
  localparam logic [7:0] ASC_LF     = 8'h0A;

  // Fixed loop bound keeps this a constant mux when e is not elaboration-time.
  function automatic logic [ACC_W-1:0] pow10(input int e);
    logic [ACC_W-1:0] r;
    r = ACC_W'(1);
    for (int i = 0; i < 10; i++) begin
      if (i < e) r = r * ACC_W'(10);
    end
    return r;
  endfunction

  function automatic logic is_hex(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
           (c >= 8'h61 && c <= 8'h66);
  endfunction

  function automatic logic [3:0] hex_val(input logic [7:0] c);
    return (c <= 8'h39) ? c[3:0] : c[3:0] + 4'd9;
  endfunction

endpackage

// File: rtl/pos_to_map.sv
// Map stage: fixed-point minutes to saturated pixel coordinates, one register stage.
// Outputs update and pos_valid_o pulses the cycle after go_i.
module pos_to_map
  import nmea_pkg::*;
#(
  parameter int COORD_W = 9,
  parameter int MAP_W   = 320,
  parameter int MAP_H   = 240,
  parameter int LAT0    = 18350000,
  parameter int LON0    = 68610000,
  parameter int SHIFT   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go_i,
  input  logic [ACC_W-1:0]   lat_i,
  input  logic [ACC_W-1:0]   lon_i,
  output logic [COORD_W-1:0] m_o,
  output logic [COORD_W-1:0] n_o,
  output logic               in_region_o,
  output logic               pos_valid_o
);

  localparam logic signed [ACC_W:0] LAT0_S = (ACC_W+1)'(LAT0);
  localparam logic signed [ACC_W:0] LON0_S = (ACC_W+1)'(LON0);
  localparam logic signed [ACC_W:0] MAPW_S = (ACC_W+1)'(MAP_W);
  localparam logic signed [ACC_W:0] MAPH_S = (ACC_W+1)'(MAP_H);

  logic signed [ACC_W:0] dx, dy, mx, ny;
  logic                  in_m, in_n;
  logic [COORD_W-1:0]    m_d, n_d, m_q, n_q;
  logic                  in_q, pv_q;

  always_comb begin
    dx   = $signed({1'b0, lon_i}) - LON0_S;
    dy   = LAT0_S - $signed({1'b0, lat_i});
    mx   = dx >>> SHIFT;
    ny   = dy >>> SHIFT;
    in_m = !mx[ACC_W] && (mx < MAPW_S);
    in_n = !ny[ACC_W] && (ny < MAPH_S);
    if (mx[ACC_W])  m_d = '0;
    else if (!in_m) m_d = COORD_W'(MAP_W - 1);
    else            m_d = mx[COORD_W-1:0];
    if (ny[ACC_W])  n_d = '0;
    else if (!in_n) n_d = COORD_W'(MAP_H - 1);
    else            n_d = ny[COORD_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q  <= '0;
      n_q  <= '0;
      in_q <= 1'b0;
      pv_q <= 1'b0;
    end else begin
      pv_q <= go_i;
      if (go_i) begin
        m_q  <= m_d;
        n_q  <= n_d;
        in_q <= in_m && in_n;
      end
    end
  end

  assign m_o         = m_q;
  assign n_o         = n_q;
  assign in_region_o = in_q;
  assign pos_valid_o = pv_q;

endmodule

// File: rtl/nmea_pos_mapper.sv
// $GxRMC parser feeding pos_to_map; m/n update 2 cycles after the committing LF.
// Optional checksum verification under NMEA_CKSUM_EN; one byte per cycle, no backpressure.
module nmea_pos_mapper
  import nmea_pkg::*;
#(
  parameter int FRAC_DIGITS = 4,
  parameter int COORD_W     = 9,
  parameter int MAP_W       = 320,
  parameter int MAP_H       = 240,
  parameter int LAT0        = 18350000,
  parameter int LON0        = 68610000,
  parameter int SHIFT       = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [COORD_W-1:0] m,
  output logic [COORD_W-1:0] n,
  output logic               in_region,
  output logic               fix_valid,
  output logic               pos_valid,
  output logic               frame_err
);

  state_e           state_q;
  logic [2:0]       cnt_q, icnt_q;
  logic [4:0]       fcnt_q;
  logic             dot_q, status_a_q, lat_ok_q, lon_ok_q, fix_q, ferr_q;
  logic [ACC_W-1:0] deg_q, min_q, frac_q, lat_q, lon_q;
  logic [7:0]       ck_q;
  logic [3:0]       ck_hi_q;

  logic             is_dig, talk_ok, fld_end_ok, fld_full, commit_ok, in_ck_span;
  logic [2:0]       degd;
  logic [ACC_W-1:0] dig, fld_val;

  always_comb begin
    is_dig     = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    dig        = ACC_W'(rx_data[3:0]);
    degd       = (state_q == S_LON) ? 3'd3 : 3'd2;
    fld_full   = (icnt_q != 3'd0) || dot_q;
    fld_end_ok = dot_q || (icnt_q == 3'd0) || (icnt_q == degd + 3'd2);
    fld_val    = (deg_q * ACC_W'(60) + min_q) * pow10(FRAC_DIGITS) +
                 frac_q * pow10(FRAC_DIGITS - int'(fcnt_q));
    commit_ok  = status_a_q && lat_ok_q && lon_ok_q;
    in_ck_span = (state_q inside {S_TALKER, S_TIME, S_STATUS, S_LAT, S_LAT_HEM,
                                  S_LON, S_LON_HEM, S_TAIL}) && (rx_data != ASC_STAR);
    case (cnt_q)
      3'd0:    talk_ok = (rx_data == 8'h47);
      3'd1:    talk_ok = 1'b1;
      3'd2:    talk_ok = (rx_data == 8'h52);
      3'd3:    talk_ok = (rx_data == 8'h4D);
      3'd4:    talk_ok = (rx_data == 8'h43);
      default: talk_ok = (rx_data == ASC_COMMA);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0; icnt_q <= '0; fcnt_q <= '0; dot_q <= 1'b0;
      deg_q <= '0; min_q <= '0; frac_q <= '0; lat_q <= '0; lon_q <= '0;
      status_a_q <= 1'b0; lat_ok_q <= 1'b0; lon_ok_q <= 1'b0;
      ck_q <= '0; ck_hi_q <= '0; fix_q <= 1'b0; ferr_q <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      if (state_q == S_MAP) state_q <= S_IDLE;
      // Field accumulators are only live inside LAT/LON; start each field clean.
      if (!(state_q inside {S_LAT, S_LON})) begin
        icnt_q <= '0; fcnt_q <= '0; dot_q <= 1'b0;
        deg_q <= '0; min_q <= '0; frac_q <= '0;
      end
      if (rx_valid) begin
        if (rx_data == ASC_DOLLAR) begin
          state_q <= S_TALKER;
          cnt_q <= '0; ck_q <= '0;
          status_a_q <= 1'b0; lat_ok_q <= 1'b0; lon_ok_q <= 1'b0;
        end else begin
          if (in_ck_span) ck_q <= ck_q ^ rx_data;
          case (state_q)
            S_TALKER: begin
              cnt_q <= cnt_q + 3'd1;
              if (!talk_ok)            state_q <= S_IDLE;
              else if (cnt_q == 3'd5)  state_q <= S_TIME;
            end
            S_TIME:   if (rx_data == ASC_COMMA) state_q <= S_STATUS;
            S_STATUS: begin
              if (rx_data == ASC_COMMA) state_q <= S_LAT;
              else status_a_q <= (rx_data == 8'h41);
            end
            S_LAT, S_LON: begin
              if (rx_data == ASC_COMMA) begin
                if (!fld_end_ok) begin
                  ferr_q <= 1'b1; state_q <= S_IDLE;
                end else if (state_q == S_LAT) begin
                  lat_q <= fld_val; lat_ok_q <= fld_full; state_q <= S_LAT_HEM;
                end else begin
                  lon_q <= fld_val; lon_ok_q <= fld_full; state_q <= S_LON_HEM;
                end
              end else if (rx_data == ASC_DOT) begin
                if (dot_q || icnt_q != degd + 3'd2) begin
                  ferr_q <= 1'b1; state_q <= S_IDLE;
                end else dot_q <= 1'b1;
              end else if (!is_dig || (!dot_q && icnt_q == degd + 3'd2)) begin
                ferr_q <= 1'b1; state_q <= S_IDLE;
              end else if (dot_q) begin
                if (int'(fcnt_q) < FRAC_DIGITS) begin
                  frac_q <= frac_q * ACC_W'(10) + dig;
                  fcnt_q <= fcnt_q + 5'd1;
                end
              end else begin
                if (icnt_q < degd) deg_q <= deg_q * ACC_W'(10) + dig;
                else               min_q <= min_q * ACC_W'(10) + dig;
                icnt_q <= icnt_q + 3'd1;
              end
            end
            S_LAT_HEM: begin
              if (rx_data == ASC_COMMA) state_q <= S_LON;
              else if (rx_data != 8'h4E) begin ferr_q <= 1'b1; state_q <= S_IDLE; end
            end
            S_LON_HEM: begin
              if (rx_data == ASC_COMMA) state_q <= S_TAIL;
              else if (rx_data != 8'h45) begin ferr_q <= 1'b1; state_q <= S_IDLE; end
            end
            S_TAIL: begin
`ifdef NMEA_CKSUM_EN
              if (rx_data == ASC_LF) begin
                ferr_q <= 1'b1; state_q <= S_IDLE;
              end else if (rx_data == ASC_STAR) state_q <= S_CK_HI;
`else
              if (rx_data == ASC_LF) begin
                fix_q   <= commit_ok;
                state_q <= commit_ok ? S_MAP : S_IDLE;
              end
`endif
            end
            S_CK_HI: begin
              if (is_hex(rx_data)) begin
                ck_hi_q <= hex_val(rx_data); cnt_q <= '0; state_q <= S_CK_LO;
              end else begin
                ferr_q <= 1'b1; state_q <= S_IDLE;
              end
            end
            S_CK_LO: begin
              if (cnt_q == 3'd0) begin
                if (!is_hex(rx_data) || {ck_hi_q, hex_val(rx_data)} != ck_q) begin
                  ferr_q <= 1'b1; state_q <= S_IDLE;
                end else cnt_q <= 3'd1;
              end else if (rx_data == ASC_LF) begin
                fix_q   <= commit_ok;
                state_q <= commit_ok ? S_MAP : S_IDLE;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  pos_to_map #(
    .COORD_W(COORD_W), .MAP_W(MAP_W), .MAP_H(MAP_H),
    .LAT0(LAT0), .LON0(LON0), .SHIFT(SHIFT)
  ) u_map (
    .clk(clk), .rst(rst), .go_i(state_q == S_MAP),
    .lat_i(lat_q), .lon_i(lon_q),
    .m_o(m), .n_o(n), .in_region_o(in_region), .pos_valid_o(pos_valid)
  );

  assign fix_valid = fix_q;
  assign frame_err = ferr_q;

endmodule

// File: doc/nmea_pos_mapper.md
# nmea_pos_mapper

Parametrised GPS position front end for the bicycle-helper display path. Consumes the byte stream from the GPS UART receiver, parses `$GPRMC`/`$GNRMC` sentences, and converts latitude/longitude to fixed-point minutes. It then maps them to pixel coordinates `m`/`n` of a configurable map window, with saturation and an in-region flag. Its outputs feed the character-map display's `m`/`n` inputs directly.

## Interface
- `FRAC_DIGITS`, 4: fractional minute digits kept; extra digits are ignored, missing digits are zero-padded.
- `COORD_W`, 9: width of `m` and `n`.
- `MAP_W`, 320: map width in pixels.
- `MAP_H`, 240: map height in pixels.
- `LAT0`, 18350000: latitude of the top map edge, in units of 10^-FRAC_DIGITS minutes (30°35.0000' N).
- `LON0`, 68610000: longitude of the left map edge, same units (114°21.0000' E).
- `SHIFT`, 6: units per pixel = 2^SHIFT.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid this cycle.
- `m` out COORD_W: column (east offset), registered, held between fixes.
- `n` out COORD_W: row (south offset), registered, held between fixes.
- `in_region` out 1: last committed fix lies inside the map.
- `fix_valid` out 1: level; status field of the last accepted sentence was 'A'.
- `pos_valid` out 1: one-cycle pulse; `m`/`n`/`in_region` were updated.
- `frame_err` out 1: one-cycle pulse; a sentence was discarded.

## Operation
- Reset: all outputs 0, FSM in IDLE, accumulators cleared.
- FSM states: IDLE, TALKER, TIME, STATUS, LAT, LAT_HEM, LON, LON_HEM, TAIL, CK_HI, CK_LO, MAP.
- IDLE -> TALKER on '$'. A '$' in any state restarts at TALKER and discards the partial sentence without pulsing `frame_err`.
- TALKER checks 5 characters: 'G', any talker letter, then "RMC". Any other sentence type returns to IDLE silently.
- Fields are comma-delimited and advance the FSM: TIME is skipped, STATUS records 'A'/'V'.
- LAT: exactly 2 degree digits, 2 minute digits, '.', then fraction digits.
- LON: exactly 3 degree digits, otherwise the same as LAT.
- Value = (deg*60 + min)*10^FRAC_DIGITS + frac. Accumulators are 28 bits, unsigned.
- The following pulse `frame_err` and return to IDLE:
  - a non-digit in a numeric field;
  - a wrong degree-digit count;
  - a hemisphere other than 'N' (LAT_HEM) or 'E' (LON_HEM).
- TAIL skips bytes up to '*' or '\n'; '\r' is ignored. '\n' triggers commit.
- Commit with status 'V' or an empty lat/lon field:
  - `fix_valid` is cleared;
  - `m`/`n`/`in_region` are held;
  - no `pos_valid` pulse.
- Commit with status 'A': `fix_valid` is set and the FSM enters MAP.
- MAP, east component: dx = lon - LON0, signed, 29 bits; m = dx >>> SHIFT.
- MAP, south component: dy = LAT0 - lat, signed, 29 bits; n = dy >>> SHIFT.
- Each result saturates to [0, MAP_W-1] for m and [0, MAP_H-1] for n.
- in_region = 1 only if both unsaturated values lie in range.
- Bytes arriving while in MAP are accepted normally; the parser is independent of the mapping register stage.

## Timing
- Byte accepted with `rx_valid` high in cycle N.
- If that byte is the committing '\n', `m`/`n`/`in_region` update and `pos_valid` pulses in cycle N+2.
- `fix_valid` updates in cycle N+1.
- `frame_err` pulses in cycle N+1 after the offending byte.
- One byte per cycle is sustained. Back-to-back `rx_valid` is legal, including a '$' in cycle N+1 after a commit.
- Reset mid-sentence discards the sentence and does not pulse `frame_err`.

## Configuration
- `NMEA_CKSUM_EN` defined:
  - XOR of bytes strictly between '$' and '*' is compared with the two hex digits after '*', upper or lower case accepted;
  - on mismatch, a non-hex digit, or '\n' before '*': `frame_err`, no commit, outputs held.
- `NMEA_CKSUM_EN` undefined:
  - bytes after '*' are ignored until '\n';
  - a sentence without '*' is accepted.

## Structure
- Package `nmea_pkg` holds:
  - the FSM state enum;
  - ASCII constants ('$', ',', '*', '.', CR, LF);
  - the accumulator width (28) and the helper function for 10^FRAC_DIGITS.
- Sub-module `pos_to_map` holds the MAP stage: subtract, arithmetic shift, saturate, in_region compare, and output registers.

## Test plan
- Valid fix with all defaults: "$GPRMC,123519,A,3033.6000,N,11422.6000,E,0.0,0.0,130623,,*hh\r\n" -> `m`=250, `n`=218, `in_region`=1, `fix_valid`=1, `pos_valid` 2 cycles after '\n'.
- Same sentence with status 'V' -> `fix_valid`=0, no `pos_valid`, previous `m`/`n` held.
- Longitude 11420.0000 (west of LON0) -> `m`=0, `n`=218, `in_region`=0, `pos_valid` pulses.
- Latitude "3O33.6000" (letter O) -> `frame_err` 1 cycle after that byte, no commit.
- Sentence cut by a '$' mid-latitude, followed by a complete valid sentence -> no `frame_err`, exactly one `pos_valid` carrying the second sentence's values.
- With `NMEA_CKSUM_EN`: corrupted checksum digit -> `frame_err`, outputs held; without the macro the same stream -> `pos_valid`.
